// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one adder datapath between
// NUM_REQ valid/ready requesters, with a one-entry registered result stage.

// adder: plain DATA_WIDTH-bit ripple-style adder with carry in/out.
module adder #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  // Full-width addition; the top bit of the widened sum is the carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};

endmodule

module adder_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_cout,
  output logic [ID_WIDTH-1:0]           rsp_id
);

  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   winner;
  logic                  found;
  logic                  can_accept;
  logic                  fire;
  logic [DATA_WIDTH-1:0] x_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] y_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] x_sel;
  logic [DATA_WIDTH-1:0] y_sel;
  logic                  cin_sel;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_cout;

  // Unpack the flat operand buses so the mux can index by requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*DATA_WIDTH +: DATA_WIDTH];
    assign y_arr[g] = req_y[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan: first valid requester above last_grant, wrapping.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment would infer a latch.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        winner = ID_WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end

  // Grant the winner only when the result stage can take a new entry.
  assign can_accept = !rsp_valid || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (found && can_accept && !rst) req_ready[winner] = 1'b1;
  end

  assign fire = found && can_accept && !rst;

  // Operand mux feeding the single shared adder.
  assign x_sel   = x_arr[winner];
  assign y_sel   = y_arr[winner];
  assign cin_sel = req_cin[winner];

  adder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a    (x_sel),
    .b    (y_sel),
    .cin  (cin_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result stage and priority pointer; the pointer only moves on a fire.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else if (fire) begin
      rsp_valid  <= 1'b1;
      rsp_sum    <= add_sum;
      rsp_cout   <= add_cout;
      rsp_id     <= winner;
      last_grant <= winner;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the arbiter kept in the bench.
module tb_adder_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_x;
  logic [NR*DW-1:0] req_y;
  logic [NR-1:0]    req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_sum;
  logic             rsp_cout;
  logic [IW-1:0]    rsp_id;

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: result register contents and last granted requester.
  bit            m_valid;
  int            m_sum, m_cout, m_id, m_lg;
  bit            fired;
  int            fired_id;
  logic [NR-1:0] seen_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest-priority valid requester: scan upward from last grant, wrapping.
  function automatic int pick_winner();
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_lg + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sum = 0; m_cout = 0; m_id = 0; m_lg = NR - 1;
  endtask

  task automatic new_req(input int i, input int x, input int y, input int c);
    req_valid[i]        = 1'b1;
    req_x[i*DW +: DW]   = DW'(x);
    req_y[i*DW +: DW]   = DW'(y);
    req_cin[i]          = c[0];
  endtask

  // One clock: compare outputs with the model before the edge, then advance it.
  task automatic cycle();
    int            w, s;
    logic [NR-1:0] exp_ready;
    #3;
    w         = pick_winner();
    exp_ready = '0;
    fired     = 0;
    if (!rst && w >= 0 && (!m_valid || rsp_ready)) begin
      exp_ready[w] = 1'b1;
      fired        = 1;
      fired_id     = w;
    end
    seen_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_sum",   32'(rsp_sum),   32'(m_sum));
    check("rsp_cout",  32'(rsp_cout),  32'(m_cout));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (fired) begin
      s = int'(req_x[w*DW +: DW]) + int'(req_y[w*DW +: DW]) + int'(req_cin[w]);
      m_sum   = s % (1 << DW);
      m_cout  = s / (1 << DW);
      m_id    = w;
      m_lg    = w;
      m_valid = 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic retire();
    if (fired) req_valid[fired_id] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();

    // Single request on requester 2: 7+8+1 wraps to 0 with carry.
    new_req(2, 7, 8, 1);
    cycle(); retire();
    check("t1_ready", 32'(seen_ready), 32'h4);
    check("t1_valid", 32'(rsp_valid), 32'h1);
    check("t1_sum",   32'(rsp_sum),   32'h0);
    check("t1_cout",  32'(rsp_cout),  32'h1);
    check("t1_id",    32'(rsp_id),    32'h2);
    cycle();

    // All four continuously valid: ids 0,1,2,3,0,1 back to back.
    do_reset();
    for (int i = 0; i < NR; i++) new_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    for (int n = 0; n < 6; n++) begin
      cycle();
      if (fired) new_req(fired_id, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      check("rr_valid", 32'(rsp_valid), 32'h1);
      check("rr_id",    32'(rsp_id),    32'(n % NR));
    end
    req_valid = '0;
    cycle();

    // Backpressure: result held three cycles, then requester 1 wins.
    do_reset();
    new_req(0, 3, 4, 0);
    cycle(); retire();
    rsp_ready = 1'b0;
    new_req(1, 5, 9, 1);
    new_req(3, 2, 2, 0);
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("bp_ready", 32'(seen_ready), 32'h0);
      check("bp_sum",   32'(rsp_sum),    32'h7);
      check("bp_id",    32'(rsp_id),     32'h0);
    end
    rsp_ready = 1'b1;
    cycle(); retire();
    check("bp_grant", 32'(seen_ready), 32'h2);
    check("bp_id1",   32'(rsp_id),     32'h1);
    check("bp_sum1",  32'(rsp_sum),    32'hF);
    cycle(); retire();
    cycle();

    // Priority rotation: after 0 fires, 3 beats 0.
    do_reset();
    new_req(0, 1, 1, 0);
    cycle(); retire();
    new_req(0, 2, 2, 0);
    new_req(3, 4, 4, 0);
    cycle(); retire();
    check("rot_first",  32'(seen_ready), 32'h8);
    cycle(); retire();
    check("rot_second", 32'(seen_ready), 32'h1);
    cycle();

    // Reset mid-operation with all requesters valid.
    for (int i = 0; i < NR; i++) new_req(i, i + 5, i, 1);
    cycle(); retire(); new_req(fired_id, 6, 6, 0);
    check("mid_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_ready", 32'(seen_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid),  32'h0);
    check("rst_sum",   32'(rsp_sum),    32'h0);
    cycle(); retire();
    check("rst_first", 32'(seen_ready), 32'h1);
    req_valid = '0;
    cycle();

    // Corner sums.
    new_req(1, 0, 0, 0);
    cycle(); retire();
    check("c0_sum", 32'(rsp_sum), 32'h0);  check("c0_cout", 32'(rsp_cout), 32'h0);
    new_req(2, 15, 15, 1);
    cycle(); retire();
    check("c1_sum", 32'(rsp_sum), 32'hF);  check("c1_cout", 32'(rsp_cout), 32'h1);
    new_req(3, 9, 6, 0);
    cycle(); retire();
    check("c2_sum", 32'(rsp_sum), 32'hF);  check("c2_cout", 32'(rsp_cout), 32'h0);
    new_req(0, 15, 1, 0);
    cycle(); retire();
    check("c3_sum", 32'(rsp_sum), 32'h0);  check("c3_cout", 32'(rsp_cout), 32'h1);
    cycle();

    // Randomized traffic: requests held until they fire, random backpressure.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          new_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
      retire();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
